// File: rtl/dcache_responder.sv
// dcache_responder: memory end of the back end's load/store port.
// One request in flight at a time; a DEPTH x 64-bit word array answers
// with a one-cycle data_valid pulse LATENCY cycles after the accept edge.
//
//   state | meaning
//   IDLE  | ready for a request (unless a flush is active)
//   WAIT  | latency countdown; a flush cancels a pending load here
//   RESP  | data_valid cycle; store bytes commit on the exit edge
module dcache_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        io_dcache_io_addr_valid,
    output logic        io_dcache_io_addr_ready,
    input  logic [63:0] io_dcache_io_addr,
    input  logic        io_dcache_io_Mwout,
    input  logic [63:0] io_dcache_io_MdataOut,
    input  logic [7:0]  io_dcache_io_wmask,
    output logic        io_dcache_io_data_valid,
    output logic [63:0] io_dcache_io_MdataIn,
    input  logic        i_flush
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic              store_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wmask_q;
    logic [63:0]       rd_data_q;
    logic [63:0]       mdata_q;
    logic [63:0]       mem [DEPTH];

    logic              ready;
    logic              data_valid;
    logic              accept;
    logic              capture_rd;
    logic              load_done;
    logic              store_commit;

    // Only the word-index bits of the byte address select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{io_dcache_io_addr[63:IDX_W+3], io_dcache_io_addr[2:0]};

    // Next-state, countdown and handshake decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready        = 1'b0;
        data_valid   = 1'b0;
        accept       = 1'b0;
        capture_rd   = 1'b0;
        load_done    = 1'b0;
        store_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // resetn gating keeps ready low for the whole reset window.
                ready = !i_flush && resetn;
                if (io_dcache_io_addr_valid && ready) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (i_flush && !store_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    capture_rd = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (store_q) begin
                    data_valid   = 1'b1;
                    store_commit = 1'b1;
                end else if (!i_flush) begin
                    // A flush landing in the response cycle still kills the load.
                    data_valid = 1'b1;
                    load_done  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counter, request latch and held load data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            store_q <= 1'b0;
            wdata_q <= 64'd0;
            wmask_q <= 8'd0;
            mdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= io_dcache_io_addr[IDX_W+2:3];
                store_q <= io_dcache_io_Mwout;
                wdata_q <= io_dcache_io_MdataOut;
                wmask_q <= io_dcache_io_wmask;
            end
            if (load_done) begin
                mdata_q <= rd_data_q;
            end
        end
    end

    // Word array: synchronous read on entry to RESP, byte-masked write on
    // exit from a store RESP. Only one request is ever in flight, so reading
    // one edge early sees the same contents as reading in RESP itself.
    // An async reset forces IDLE, so an aborted store never reaches the write.
    always_ff @(posedge clock) begin
        if (capture_rd) begin
            rd_data_q <= mem[idx_q];
        end
        if (store_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign io_dcache_io_addr_ready = ready;
    assign io_dcache_io_data_valid = data_valid;
    assign io_dcache_io_MdataIn    = load_done ? rd_data_q : mdata_q;

endmodule
